systolic_ctrl: RTL
==================

Name: systolic_ctrl

Overview:
Control sequencer directly upstream of systolic_system. On a single start pulse it latches one tile configuration, either output-stationary (OS) or weight-stationary (WS). It then drives the phase-ordered enables, operation codes and base addresses that systolic_system consumes, and it pulses done when the output buffer holds the finished tile. It replaces hand-timed control sequences with one deterministic FSM.

Parameters:
- ARRAY_N, 8, PE rows; bounds num_rows.
- ARRAY_M, 8, PE columns; bounds num_cols.
- RAM_SIZE, 256, words per buffer RAM.
- ADDR_WIDTH, $clog2(RAM_SIZE), buffer address width.
- LEN_WIDTH, 8, width of the K (OS inner length) and D (WS depth) fields.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  launch request; sampled only in IDLE.
- mode_in  in  1  1 = OS, 0 = WS.
- num_rows_in  in  $clog2(ARRAY_N)+1  R.
- num_cols_in  in  $clog2(ARRAY_M)+1  C.
- len_in  in  LEN_WIDTH  K in OS, D in WS.
- a_base_in / w_base_in / o_base_in  in  ADDR_WIDTH each  buffer base addresses.
- busy  out  1  high while a tile is in flight.
- done  out  1  one-cycle completion pulse.
- cfg_err  out  1  one-cycle pulse when start carries an illegal configuration.
- mode  out  1  latched mode to systolic_system.
- a_buf_on, w_buf_on  out  1 each  activation / weight buffer streaming enables.
- a_base_addr, w_base_addr, o_base_addr  out  ADDR_WIDTH each  latched bases.
- a_num_rows  out  $clog2(ARRAY_N)+1  latched R.
- w_num_cols  out  $clog2(ARRAY_M)+1  latched C.
- operation_signal_in  out  3  PE operation code.
- o_idx_gen_on, o_ag_o_on, o_drain  out  1 each  output-buffer controls.

Behaviour:
- Reset (reset=0 at an edge): all outputs are 0 and the FSM is in IDLE. Applies mid-tile; the tile is abandoned and no done pulse is issued.
- All outputs are registered. Start sampled at edge t makes the first-phase outputs visible from cycle t+1.
- Config check in IDLE on start. The configuration is illegal if any of these hold: R=0, C=0, R>ARRAY_N, C>ARRAY_M, len=0.
  - Illegal: cfg_err pulses for 1 cycle, the FSM stays in IDLE, nothing else changes.
  - Legal: latch all config, busy=1.
- start outside IDLE is ignored. No queueing.
- Phase lengths are counted by one down-counter, loaded with (length-1) on phase entry. The phase advances when the counter = 0. A phase of length 0 is skipped (no cycle spent).
- OS sequence:
  - OS_STREAM: K cycles; a_buf_on=w_buf_on=1, op=100.
  - OS_SKEW: R+C-1 cycles; buffers off, op=100.
  - OS_WAIT: max(ARRAY_N-R-1, 0) cycles; op=110.
  - OS_STORE: R+1 cycles; op=110, o_ag_o_on=1.
  - Then DONE.
- WS sequence:
  - WS_LOAD: C+1 cycles; w_buf_on=1, op=001.
  - WS_STREAM: D cycles; a_buf_on=1, op=000.
  - WS_OUT: D+C-1 cycles; o_idx_gen_on=1, op=000.
  - WS_DRAIN: D+1 cycles; o_drain=1, o_ag_o_on=1, op=000.
  - Then DONE.
- DONE: exactly 1 cycle. done=1, busy=0, all enables 0, op=000. Next state is IDLE.
- start asserted during DONE is ignored. The earliest accepted restart is the first IDLE cycle after DONE.
- IDLE: all enables 0, op=000, busy=0. The latched config outputs hold their last values.
- Arithmetic: phase lengths are computed at LEN_WIDTH+2 bits unsigned. The saturating subtraction in OS_WAIT never wraps.
- Total busy cycles:
  - OS: K+(R+C-1)+max(N-R-1, 0)+(R+1).
  - WS: (C+1)+D+(D+C-1)+(D+1).

Decomposition:
- Shared package systolic_pkg holds:
  - op-code constants OP_WS_FLOW=3'b000, OP_W_LOAD=3'b001, OP_OS_FLOW=3'b100, OP_OS_DRAIN=3'b110;
  - MODE_OS=1, MODE_WS=0;
  - the state enum (IDLE, OS_STREAM, OS_SKEW, OS_WAIT, OS_STORE, WS_LOAD, WS_STREAM, WS_OUT, WS_DRAIN, DONE).
- Sub-module phase_counter: a loadable down-counter with a zero flag, shared by all phases.
- The output decode is registered in systolic_ctrl itself.

Test Plan:
- OS, R=6, C=6, K=15, ARRAY_N=8, start at edge t → phase lengths 15/11/1/7; busy for 34 cycles (t+1..t+34); done pulses at t+35; op sequence 100×26 then 110×8.
- WS, R=C=5, D=8 → phase lengths 6/8/12/9; busy for 35 cycles; o_ag_o_on and o_drain high together for exactly 9 cycles; done pulses once.
- OS boundary, R=8, C=8, K=1 → OS_WAIT is skipped (0 cycles); busy for 1+15+0+9=25 cycles.
- Illegal config, start with C=0 (then R=9) → cfg_err pulses 1 cycle each time; busy stays 0; all enables stay 0.
- reset=0 during WS_STREAM → from the next edge all outputs are 0, no done pulse; a fresh start afterwards runs the full WS sequence normally.
- start held high continuously across one tile → exactly one tile executes; the next tile begins only in the IDLE cycle after DONE, i.e. 2 cycles after the done edge window.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array control slice: operation codes
// driven to the PE grid, mode encoding and the sequencer state encoding.
package systolic_pkg;

  localparam logic [2:0] OP_WS_FLOW  = 3'b000;
  localparam logic [2:0] OP_W_LOAD   = 3'b001;
  localparam logic [2:0] OP_OS_FLOW  = 3'b100;
  localparam logic [2:0] OP_OS_DRAIN = 3'b110;

  localparam logic MODE_OS = 1'b1;
  localparam logic MODE_WS = 1'b0;

  typedef enum logic [3:0] {
    IDLE,
    OS_STREAM,
    OS_SKEW,
    OS_WAIT,
    OS_STORE,
    WS_LOAD,
    WS_STREAM,
    WS_OUT,
    WS_DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter shared by every sequencer phase. It is loaded with
// (phase length - 1) on phase entry and raises zero on the last phase cycle.
module phase_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Count down toward zero and park there; a load always wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/systolic_ctrl.sv
// Tile sequencer for systolic_system. A legal start latches one tile
// configuration and walks the OS or WS phase list; every output is a
// register loaded from the decode of the next state, so phase outputs
// appear the cycle after the edge that enters the phase.
// Handshake: start is a level request honoured only in IDLE; there is no
// ready/queueing, so a start seen in any other state is simply dropped.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int ARRAY_N    = 8,
  parameter int ARRAY_M    = 8,
  parameter int RAM_SIZE   = 256,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int LEN_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mode_in,
  input  logic [$clog2(ARRAY_N):0]   num_rows_in,
  input  logic [$clog2(ARRAY_M):0]   num_cols_in,
  input  logic [LEN_WIDTH-1:0]       len_in,
  input  logic [ADDR_WIDTH-1:0]      a_base_in,
  input  logic [ADDR_WIDTH-1:0]      w_base_in,
  input  logic [ADDR_WIDTH-1:0]      o_base_in,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err,
  output logic                       mode,
  output logic                       a_buf_on,
  output logic                       w_buf_on,
  output logic [ADDR_WIDTH-1:0]      a_base_addr,
  output logic [ADDR_WIDTH-1:0]      w_base_addr,
  output logic [ADDR_WIDTH-1:0]      o_base_addr,
  output logic [$clog2(ARRAY_N):0]   a_num_rows,
  output logic [$clog2(ARRAY_M):0]   w_num_cols,
  output logic [2:0]                 operation_signal_in,
  output logic                       o_idx_gen_on,
  output logic                       o_ag_o_on,
  output logic                       o_drain,
  output logic [3:0]                 dbg_state
);

  localparam int PW = LEN_WIDTH + 2;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 cnt_load, cnt_zero, cfg_ok, accept;
  logic [PW-1:0]        cnt_val;
  logic [PW-1:0]        r_x, c_x, k_x, n_x;
  logic [PW-1:0]        l_os_skew, l_os_wait, l_os_store;
  logic [PW-1:0]        l_ws_load, l_ws_out, l_ws_drain;
  logic                 busy_d, done_d, a_on_d, w_on_d, idx_d, ag_d, drain_d;
  logic [2:0]           op_d;

  assign cfg_ok = (num_rows_in != '0) && (num_cols_in != '0) && (len_in != '0) &&
                  (int'(num_rows_in) <= ARRAY_N) && (int'(num_cols_in) <= ARRAY_M);
  assign accept = (state_q == IDLE) && start && cfg_ok;

  // In IDLE the first phase length must come from the inputs being latched.
  assign r_x = PW'((state_q == IDLE) ? num_rows_in : a_num_rows);
  assign c_x = PW'((state_q == IDLE) ? num_cols_in : w_num_cols);
  assign k_x = PW'((state_q == IDLE) ? len_in : len_q);
  assign n_x = PW'(ARRAY_N);

  assign l_os_skew  = r_x + c_x - 1'b1;
  assign l_os_wait  = (r_x + 1'b1 >= n_x) ? '0 : n_x - r_x - 1'b1;
  assign l_os_store = r_x + 1'b1;
  assign l_ws_load  = c_x + 1'b1;
  assign l_ws_out   = k_x + c_x - 1'b1;
  assign l_ws_drain = k_x + 1'b1;

  phase_counter #(.W(PW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and counter load; only OS_WAIT can have zero length.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      IDLE: if (accept) begin
        cnt_load = 1'b1;
        if (mode_in == MODE_OS) begin
          state_d = OS_STREAM;
          cnt_val = k_x - 1'b1;
        end else begin
          state_d = WS_LOAD;
          cnt_val = l_ws_load - 1'b1;
        end
      end
      OS_STREAM: if (cnt_zero) begin
        state_d = OS_SKEW; cnt_load = 1'b1; cnt_val = l_os_skew - 1'b1;
      end
      OS_SKEW: if (cnt_zero) begin
        cnt_load = 1'b1;
        if (l_os_wait != '0) begin
          state_d = OS_WAIT; cnt_val = l_os_wait - 1'b1;
        end else begin
          state_d = OS_STORE; cnt_val = l_os_store - 1'b1;
        end
      end
      OS_WAIT: if (cnt_zero) begin
        state_d = OS_STORE; cnt_load = 1'b1; cnt_val = l_os_store - 1'b1;
      end
      OS_STORE:  if (cnt_zero) state_d = DONE;
      WS_LOAD: if (cnt_zero) begin
        state_d = WS_STREAM; cnt_load = 1'b1; cnt_val = k_x - 1'b1;
      end
      WS_STREAM: if (cnt_zero) begin
        state_d = WS_OUT; cnt_load = 1'b1; cnt_val = l_ws_out - 1'b1;
      end
      WS_OUT: if (cnt_zero) begin
        state_d = WS_DRAIN; cnt_load = 1'b1; cnt_val = l_ws_drain - 1'b1;
      end
      WS_DRAIN:  if (cnt_zero) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output decode of the state being entered, registered below.
  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    a_on_d  = 1'b0;
    w_on_d  = 1'b0;
    idx_d   = 1'b0;
    ag_d    = 1'b0;
    drain_d = 1'b0;
    op_d    = OP_WS_FLOW;
    case (state_d)
      OS_STREAM: begin busy_d = 1'b1; a_on_d = 1'b1; w_on_d = 1'b1; op_d = OP_OS_FLOW; end
      OS_SKEW:   begin busy_d = 1'b1; op_d = OP_OS_FLOW; end
      OS_WAIT:   begin busy_d = 1'b1; op_d = OP_OS_DRAIN; end
      OS_STORE:  begin busy_d = 1'b1; op_d = OP_OS_DRAIN; ag_d = 1'b1; end
      WS_LOAD:   begin busy_d = 1'b1; w_on_d = 1'b1; op_d = OP_W_LOAD; end
      WS_STREAM: begin busy_d = 1'b1; a_on_d = 1'b1; end
      WS_OUT:    begin busy_d = 1'b1; idx_d = 1'b1; end
      WS_DRAIN:  begin busy_d = 1'b1; drain_d = 1'b1; ag_d = 1'b1; end
      DONE:      done_d = 1'b1;
      default:   ;
    endcase
  end

  // Output registers plus the configuration latch taken on an accepted start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy <= 1'b0; done <= 1'b0; cfg_err <= 1'b0;
      a_buf_on <= 1'b0; w_buf_on <= 1'b0; operation_signal_in <= OP_WS_FLOW;
      o_idx_gen_on <= 1'b0; o_ag_o_on <= 1'b0; o_drain <= 1'b0;
      mode <= 1'b0; a_num_rows <= '0; w_num_cols <= '0; len_q <= '0;
      a_base_addr <= '0; w_base_addr <= '0; o_base_addr <= '0;
    end else begin
      busy <= busy_d; done <= done_d;
      cfg_err <= (state_q == IDLE) && start && !cfg_ok;
      a_buf_on <= a_on_d; w_buf_on <= w_on_d; operation_signal_in <= op_d;
      o_idx_gen_on <= idx_d; o_ag_o_on <= ag_d; o_drain <= drain_d;
      if (accept) begin
        mode <= mode_in; a_num_rows <= num_rows_in; w_num_cols <= num_cols_in;
        len_q <= len_in;
        a_base_addr <= a_base_in; w_base_addr <= w_base_in; o_base_addr <= o_base_in;
      end
    end
  end

  assign dbg_state = state_q;

endmodule
